irq_trap_sched: RTL
===================

// Module: irq_trap_sched
// PURPOSE
//  Machine-mode interrupt scheduler that sits between the interrupt sources and the WB stage.
//  Synchronizes the external IRQ, prioritizes pending/enabled M-mode interrupts, holds fetch,
//  drains the pipeline, then hands one interrupt trap to WB over a req/ack handshake.
//  Drives mip pending bits to the CSR file; mode/trap_pc logic consumes its trap request.
// PARAMETERS
//  SYNC_STAGES  2   flops in ext_irq_in synchronizer (legal >= 2)
//  DRAIN_MAX    15  max HOLD cycles waiting for pipe_empty before forcing REQ (legal 1..255)
// PORTS
//  clk_in          in   1  clock
//  reset_in        in   1  reset, asynchronous, active-low
//  ext_irq_in      in   1  external IRQ, asynchronous level
//  timer_irq_in    in   1  machine timer compare level (clk_in domain)
//  sw_irq_in       in   1  machine software IRQ level (clk_in domain)
//  mode            in   2  current privilege mode (3 = M)
//  mstatus_mie     in   1  mstatus.MIE
//  mie_en          in   3  {meie,mtie,msie}
//  exception_flag  in   1  synchronous exception being taken this cycle
//  mret            in   1  MRET retiring this cycle
//  pipe_empty      in   1  no valid instructions in ID..MEM
//  trap_ack        in   1  WB has taken the interrupt trap
//  mip_pend        out  3  {meip,mtip,msip} to CSR mip
//  irq_hold        out  1  stall fetch/issue
//  trap_req        out  1  interrupt trap request to WB
//  trap_cause      out  4  mcause code (11/3/7), valid while trap_req
//  drain_timeout   out  1  1-cycle pulse when DRAIN_MAX reached
// BEHAVIOUR
//  Reset (reset_in=0, async): state=IDLE, sync flops=0, cnt=0, trap_cause=0, all outputs 0.
//  mip_pend = {sync_out, timer_irq_in, sw_irq_in}; ext latency SYNC_STAGES cycles.
//  eligible = (mode != 3) | mstatus_mie.  pend_en = mip_pend & mie_en.
//  Priority MEI(11) > MSI(3) > MTI(7); cand = eligible & |pend_en.
//  States IDLE, HOLD, REQ, COOL; irq_hold = (state != IDLE), combinational from state.
//  IDLE: cand & !exception_flag & !mret -> HOLD; latch trap_cause = winning code; cnt=0.
//  HOLD: cnt++ (8-bit, saturates, no wrap).
//    exception_flag=1 -> IDLE (exception wins; interrupt re-evaluated from IDLE).
//    else !cand -> IDLE (source withdrawn or disabled before request).
//    else pipe_empty -> REQ; trap_cause re-latched to current winner on this transition.
//    else cnt==DRAIN_MAX-1 -> REQ, drain_timeout=1 for that one cycle.
//  REQ: trap_req = !exception_flag (combinational). trap_cause held stable, not re-evaluated;
//    source deassertion in REQ does not withdraw the request.
//    exception_flag=1 -> IDLE, trap_req 0 that cycle, trap_ack ignored.
//    trap_ack=1 (and no exception) -> COOL.
//  COOL: exactly 1 cycle, irq_hold stays 1 so CSR can clear mstatus.MIE; -> IDLE.
//  trap_ack while not in REQ: ignored. mret in HOLD/REQ: no effect.
//  Minimum IRQ-to-trap_req latency with pipe_empty=1: 2 cycles after cand (IDLE->HOLD->REQ).
//  Reset asserted in any state: immediate IDLE, trap_req/irq_hold drop asynchronously.
// TESTING
//  1. mode=3,MIE=1,mie_en=3'b010,timer=1,pipe_empty=1 -> irq_hold@+1, trap_req & cause=7 @+2;
//     ack -> COOL 1 cycle -> IDLE.
//  2. ext=1,timer=1,sw=1, all enabled -> cause=11; with mie_en=3'b011 -> cause=3.
//  3. pipe_empty=0 forever, DRAIN_MAX=15 -> drain_timeout pulse & trap_req 15 cycles after HOLD.
//  4. exception_flag=1 in REQ -> trap_req=0 same cycle, ack ignored, state IDLE next cycle.
//  5. mode=3,MIE=0,timer=1,mtie=1 -> never leaves IDLE; set mode=0 -> request issued.
//  6. reset_in low mid-REQ -> all outputs 0 without clock edge; ext pulse < SYNC_STAGES after release ignored.

Source files
------------

// File: rtl/irq_trap_sched.sv
// Machine-mode interrupt scheduler: synchronizes the external IRQ, picks the highest-priority
// enabled interrupt, holds fetch while the pipeline drains, then hands one trap to WB.
module irq_trap_sched #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DRAIN_MAX   = 15
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       ext_irq_in,
    input  logic       timer_irq_in,
    input  logic       sw_irq_in,
    input  logic [1:0] mode,
    input  logic       mstatus_mie,
    input  logic [2:0] mie_en,
    input  logic       exception_flag,
    input  logic       mret,
    input  logic       pipe_empty,
    input  logic       trap_ack,
    output logic [2:0] mip_pend,
    output logic       irq_hold,
    output logic       trap_req,
    output logic [3:0] trap_cause,
    output logic       drain_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REQ,
        COOL
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);
    localparam logic [3:0] CODE_MEI   = 4'd11;
    localparam logic [3:0] CODE_MSI   = 4'd3;
    localparam logic [3:0] CODE_MTI   = 4'd7;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt;
    logic [7:0]             cnt_next;
    logic [3:0]             cause_q;
    logic [3:0]             cause_next;
    logic [3:0]             win_code;
    logic [2:0]             pend_en;
    logic                   eligible;
    logic                   cand;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
        end
    end

    assign mip_pend = {sync_q[SYNC_STAGES-1], timer_irq_in, sw_irq_in};
    assign eligible = (mode != 2'd3) | mstatus_mie;
    assign pend_en  = mip_pend & mie_en;
    assign cand     = eligible & (|pend_en);

    // Bit order is {meip,mtip,msip}; software outranks timer.
    always_comb begin
        win_code = '0;
        if (pend_en[2]) begin
            win_code = CODE_MEI;
        end else if (pend_en[0]) begin
            win_code = CODE_MSI;
        end else if (pend_en[1]) begin
            win_code = CODE_MTI;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state   <= IDLE;
            cnt     <= '0;
            cause_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cause_next    = cause_q;
        trap_req      = 1'b0;
        drain_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (cand && !exception_flag && !mret) begin
                    state_next = HOLD;
                    cause_next = win_code;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                if (exception_flag) begin
                    state_next = IDLE;
                end else if (!cand) begin
                    state_next = IDLE;
                end else if (pipe_empty) begin
                    state_next = REQ;
                    cause_next = win_code;
                end else if (cnt == DRAIN_LAST) begin
                    state_next    = REQ;
                    drain_timeout = 1'b1;
                end
            end
            REQ: begin
                trap_req = !exception_flag;
                if (exception_flag) begin
                    state_next = IDLE;
                end else if (trap_ack) begin
                    state_next = COOL;
                end
            end
            COOL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign irq_hold   = (state != IDLE);
    assign trap_cause = cause_q;

endmodule
